// File: rtl/neuron_sched_pkg.sv
// Shared types for the neuron slot scheduler: FSM states, per-slot phases and strobe encoding.
package neuron_sched_pkg;

  localparam int unsigned OVR_W  = 16;
  localparam int unsigned STEP_W = 32;
  localparam int unsigned PH_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [PH_W-1:0] {
    PH_COUNT  = 2'd0,
    PH_READ   = 2'd1,
    PH_SETTLE = 2'd2,
    PH_WRITE  = 2'd3
  } phase_e;

  typedef struct packed {
    logic count;
    logic read;
    logic write;
  } strobe_t;

  // Phase order within one neuron slot.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_COUNT:  return PH_READ;
      PH_READ:   return PH_SETTLE;
      PH_SETTLE: return PH_WRITE;
      default:   return PH_COUNT;
    endcase
  endfunction

  // One-hot strobe for a phase; SETTLE drives none.
  function automatic strobe_t phase_strobes(input phase_e p);
    strobe_t s;
    s = '0;
    case (p)
      PH_COUNT: s.count = 1'b1;
      PH_READ:  s.read  = 1'b1;
      PH_WRITE: s.write = 1'b1;
      default:  s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/phase_tick_div.sv
// Phase divider: tick is high on the last of div_q+1 unheld clocks of a phase.
module phase_tick_div #(
  parameter int unsigned DIVW = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            hold,
  input  logic            clear,
  input  logic [DIVW-1:0] div_q,
  output logic            tick
);

  logic [DIVW-1:0] cnt_q;

  assign tick = !hold && (cnt_q == div_q);

  // Count is preserved across hold so a paused phase resumes where it left off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= tick ? '0 : cnt_q + DIVW'(1);
    end
  end

endmodule

// File: rtl/neuron_slot_scheduler.sv
// Sequences COUNT/READ/SETTLE/WRITE phases over all neuron slots once per simulation step.
// Optional step counter enabled by macro SCHED_STEP_CNT_EN.
module neuron_slot_scheduler
  import neuron_sched_pkg::*;
#(
  parameter int unsigned NN   = 8,
  parameter int unsigned DIVW = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              step_req,
  input  logic              cont,
  input  logic              cfg_load,
  input  logic [DIVW-1:0]   div_in,
  output logic [NN-1:0]     neuron_idx,
  output logic              ph_count,
  output logic              ph_read,
  output logic              ph_write,
  output logic              first_neuron,
  output logic              busy,
  output logic              step_done,
  output logic [OVR_W-1:0]  overrun_cnt,
  output logic [STEP_W-1:0] step_cnt
);

  localparam logic [NN-1:0] IDX_LAST = '1;

  state_e          state_q, state_n;
  phase_e          phase_q, phase_n;
  logic [NN-1:0]   idx_n;
  logic            start;
  logic            tick;
  logic            hold;
  strobe_t         strobe_n;
  logic            first_n;
  logic            busy_n;
  logic            done_n;
  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] pend_val;
  logic            pend_q;

  assign hold = !((state_q == ST_RUN) && enable);

  phase_tick_div #(.DIVW(DIVW)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (hold),
    .clear   (start),
    .div_q   (div_q),
    .tick    (tick)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state_q;
    phase_n  = phase_q;
    idx_n    = neuron_idx;
    start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (step_req && enable) begin
          state_n = ST_RUN;
          phase_n = PH_COUNT;
          idx_n   = '0;
          start   = 1'b1;
        end
      end
      ST_RUN: begin
        if (tick) begin
          phase_n = next_phase(phase_q);
          if (phase_q == PH_WRITE) begin
            if (neuron_idx == IDX_LAST) begin
              state_n = ST_DONE;
              idx_n   = '0;
            end else begin
              idx_n = neuron_idx + NN'(1);
            end
          end
        end
      end
      ST_DONE: begin
        if (cont && enable) begin
          state_n = ST_RUN;
          phase_n = PH_COUNT;
          idx_n   = '0;
          start   = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    strobe_n = ((state_n == ST_RUN) && enable) ? phase_strobes(phase_n) : '0;
    first_n  = (state_n == ST_RUN) && (idx_n == '0);
    busy_n   = (state_n != ST_IDLE);
    done_n   = (state_n == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_COUNT;
      neuron_idx   <= '0;
      ph_count     <= 1'b0;
      ph_read      <= 1'b0;
      ph_write     <= 1'b0;
      first_neuron <= 1'b0;
      busy         <= 1'b0;
      step_done    <= 1'b0;
    end else begin
      state_q      <= state_n;
      phase_q      <= phase_n;
      neuron_idx   <= idx_n;
      ph_count     <= strobe_n.count;
      ph_read      <= strobe_n.read;
      ph_write     <= strobe_n.write;
      first_neuron <= first_n;
      busy         <= busy_n;
      step_done    <= done_n;
    end
  end

  // Divider config: direct in IDLE, otherwise parked until the next step starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      pend_val <= '0;
      pend_q   <= 1'b0;
    end else if ((state_q == ST_IDLE) && cfg_load) begin
      div_q  <= div_in;
      pend_q <= 1'b0;
    end else if (start) begin
      if (cfg_load) begin
        div_q <= div_in;
      end else if (pend_q) begin
        div_q <= pend_val;
      end
      pend_q <= 1'b0;
    end else if (cfg_load) begin
      pend_val <= div_in;
      pend_q   <= 1'b1;
    end
  end

  // Rejected step requests, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_cnt <= '0;
    end else if (step_req && (state_q != ST_IDLE) && (overrun_cnt != '1)) begin
      overrun_cnt <= overrun_cnt + OVR_W'(1);
    end
  end

`ifdef SCHED_STEP_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt <= '0;
    end else if (done_n) begin
      step_cnt <= step_cnt + STEP_W'(1);
    end
  end
`else
  assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_neuron_slot_scheduler.sv
// Bench for neuron_slot_scheduler: step-position reference model checked every cycle,
// a table of timing scenarios, hand-written overrun/config/reset sequences and random traffic.
module tb_neuron_slot_scheduler;

  localparam int NN    = 2;
  localparam int DIVW  = 8;
  localparam int NSLOT = 1 << NN;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic            step_req;
  logic            cont;
  logic            cfg_load;
  logic [DIVW-1:0] div_in;
  logic [NN-1:0]   neuron_idx;
  logic            ph_count, ph_read, ph_write, first_neuron, busy, step_done;
  logic [15:0]     overrun_cnt;
  logic [31:0]     step_cnt;

  int total = 0;
  int bad   = 0;

  neuron_slot_scheduler #(.NN(NN), .DIVW(DIVW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .step_req     (step_req),
    .cont         (cont),
    .cfg_load     (cfg_load),
    .div_in       (div_in),
    .neuron_idx   (neuron_idx),
    .ph_count     (ph_count),
    .ph_read      (ph_read),
    .ph_write     (ph_write),
    .first_neuron (first_neuron),
    .busy         (busy),
    .step_done    (step_done),
    .overrun_cnt  (overrun_cnt),
    .step_cnt     (step_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 run, 2 done; pos = unfrozen clocks elapsed in the step.
  int          m_mode;
  int unsigned m_pos;
  bit          m_frozen;
  int unsigned m_div;
  bit          m_pend;
  int unsigned m_pend_val;
  logic [15:0] m_ovr;
  logic [31:0] m_steps;

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_frozen = 0; m_div = 0;
    m_pend = 0; m_pend_val = 0; m_ovr = '0; m_steps = '0;
  endtask

  task automatic model_step();
    int unsigned tot;
    bit start, was_idle;
    if (!reset_n) begin
      model_reset();
      return;
    end
    tot      = 4 * NSLOT * (m_div + 1);
    start    = 0;
    was_idle = (m_mode == 0);
    if (step_req && !was_idle && m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
    case (m_mode)
      0: if (step_req && enable) start = 1;
      1: begin
        m_frozen = !enable;
        if (enable) begin
          m_pos++;
          if (m_pos == tot) begin
            m_mode  = 2;
            m_steps = m_steps + 32'd1;
          end
        end
      end
      default: if (cont && enable) start = 1; else m_mode = 0;
    endcase
    if (was_idle) begin
      if (cfg_load) begin m_div = int'(div_in); m_pend = 0; end
      else if (start && m_pend) begin m_div = m_pend_val; m_pend = 0; end
    end else if (start) begin
      if (cfg_load) m_div = int'(div_in);
      else if (m_pend) m_div = m_pend_val;
      m_pend = 0;
    end else if (cfg_load) begin
      m_pend = 1; m_pend_val = int'(div_in);
    end
    if (start) begin
      m_mode = 1; m_pos = 0; m_frozen = 0;
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int unsigned d1, ph, ix;
    bit run, live;
    logic [63:0] act, exp;
    logic [31:0] exp_steps;
    d1   = m_div + 1;
    run  = (m_mode == 1);
    live = run && !m_frozen;
    ph   = run ? (m_pos / d1) % 4 : 0;
    ix   = run ? m_pos / (4 * d1) : 0;
`ifdef SCHED_STEP_CNT_EN
    exp_steps = m_steps;
`else
    exp_steps = '0;
`endif
    act = {8'd0, 6'(neuron_idx), ph_count, ph_read, ph_write, first_neuron, busy, step_done,
           overrun_cnt, step_cnt};
    exp = {8'd0, 6'(ix), live && ph == 0, live && ph == 1, live && ph == 3,
           run && ix == 0, m_mode != 0, m_mode == 2, m_ovr, exp_steps};
    check("outputs", act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic load_div(input int d);
    cfg_load = 1; div_in = DIVW'(d);
    cyc();
    cfg_load = 0;
  endtask

  // One step from IDLE; optional enable freeze or mid-step overrun/config injection.
  task automatic run_step(input int frz_at, input int frz_len, input bit inject,
                          output int run_len, output int read_hi);
    int left, guard;
    step_req = 1;
    cyc();
    step_req = 0;
    run_len = 0; read_hi = 0; left = 0; guard = 0;
    while (busy && !step_done && guard < 600) begin
      if (run_len == frz_at) begin
        left = frz_len;
        check("freeze_point_read_idx1", {62'd0, neuron_idx == NN'(1), ph_read}, 64'd3);
      end
      if (ph_read) read_hi++;
      if (left > 0) begin enable = 0; left--; end else enable = 1;
      if (inject) begin
        step_req = (run_len == 3 || run_len == 6 || run_len == 9);
        cfg_load = (run_len == 10);
        div_in   = DIVW'(1);
      end
      run_len++; guard++;
      cyc();
    end
    enable = 1; step_req = 0; cfg_load = 0;
    check("done_pulse", {63'd0, step_done}, 64'd1);
    cyc();
  endtask

  typedef struct {
    int div;
    int frz_at;
    int frz_len;
    int exp_run;
    int exp_read;
  } vec_t;

  vec_t vt[6];

  initial begin
    int rl, rh, dn, g;
    vt[0] = '{div: 0, frz_at: -1, frz_len: 0, exp_run: 16, exp_read: 4};
    vt[1] = '{div: 2, frz_at: -1, frz_len: 0, exp_run: 48, exp_read: 12};
    vt[2] = '{div: 1, frz_at: -1, frz_len: 0, exp_run: 32, exp_read: 8};
    vt[3] = '{div: 0, frz_at: 5,  frz_len: 5, exp_run: 21, exp_read: 4};
    vt[4] = '{div: 2, frz_at: 16, frz_len: 5, exp_run: 53, exp_read: 12};
    vt[5] = '{div: 3, frz_at: -1, frz_len: 0, exp_run: 64, exp_read: 16};

    reset_n = 0; enable = 1; step_req = 0; cont = 0; cfg_load = 0; div_in = '0;
    model_reset();
    repeat (3) cyc();
    reset_n = 1;
    cyc();
    check("reset_busy", {63'd0, busy}, 64'd0);

    // Overruns and a config load mid-step: old timing now, 2-clock phases next step.
    load_div(0);
    run_step(-1, 0, 1'b1, rl, rh);
    check("ovr_step_run_len", 64'(rl), 64'd16);
    check("ovr_count", 64'(overrun_cnt), 64'd3);
    run_step(-1, 0, 1'b0, rl, rh);
    check("pending_div_run_len", 64'(rl), 64'd32);

    for (int i = 0; i < 6; i++) begin
      load_div(vt[i].div);
      run_step(vt[i].frz_at, vt[i].frz_len, 1'b0, rl, rh);
      check($sformatf("vec%0d_run_len", i), 64'(rl), 64'(vt[i].exp_run));
      check($sformatf("vec%0d_read_clocks", i), 64'(rh), 64'(vt[i].exp_read));
    end

    // step_req during DONE is an overrun and does not start a step.
    load_div(0);
    step_req = 1; cyc(); step_req = 0;
    repeat (16) cyc();
    step_req = 1; cyc(); step_req = 0;
    check("done_req_idle", {63'd0, busy}, 64'd0);
    check("done_req_ovr", 64'(overrun_cnt), 64'd4);

    // Continuous mode with reset asserted in step 3 at idx 2.
    cont = 1; step_req = 1; cyc(); step_req = 0;
    dn = 0; g = 0;
    while (!(dn == 2 && busy && neuron_idx == NN'(2)) && g < 300) begin
      if (step_done) dn++;
      cyc();
      g++;
    end
    check("cont_done_pulses", 64'(dn), 64'd2);
    #2 reset_n = 0;
    #1;
    model_reset();
    check("async_reset_outputs",
          {neuron_idx, ph_count, ph_read, ph_write, first_neuron, busy, step_done, overrun_cnt, step_cnt},
          64'd0);
    cyc();
    reset_n = 1;
    repeat (10) cyc();
    check("post_reset_idle", {63'd0, busy}, 64'd0);
    cont = 0;

    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      step_req = ($urandom_range(0, 19) == 0);
      cont     = ($urandom_range(0, 3) == 0);
      cfg_load = ($urandom_range(0, 29) == 0);
      div_in   = DIVW'($urandom_range(0, 3));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_slot_scheduler.md
NEURON_SLOT_SCHEDULER -- requirements
Module: neuron_slot_scheduler

Interface
REQ-001 SHALL have parameter NN, default 8: neuron-index width; neuron count N = 2**NN.
REQ-002 SHALL have parameter DIVW, default 32: phase-divider width.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: run permission; low pauses sequencing.
REQ-006 SHALL have port step_req, input, 1: single-cycle request for one simulation step.
REQ-007 SHALL have port cont, input, 1: continuous mode; a new step starts automatically after DONE.
REQ-008 SHALL have port cfg_load, input, 1: strobe that captures div_in.
REQ-009 SHALL have port div_in, input, DIVW: clocks per phase, minus 1.
REQ-010 SHALL have port neuron_idx, output, NN: current neuron slot, used as RAM address.
REQ-011 SHALL have port ph_count, ph_read, ph_write, output, 1 each: one-hot phase strobes.
REQ-012 SHALL have port first_neuron, output, 1: high throughout slot 0 while busy.
REQ-013 SHALL have port busy, output, 1; step_done, output, 1: single-cycle step-completion pulse.
REQ-014 SHALL have port overrun_cnt, output, 16: count of step_req pulses rejected while busy.
REQ-015 SHALL have port step_cnt, output, 32: count of completed steps.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE; RUN SHALL carry phase COUNT->READ->SETTLE->WRITE per slot.
REQ-017 IDLE: step_req=1 with enable=1 SHALL enter RUN at idx 0, phase COUNT, visible on the following cycle.
REQ-018 Each phase SHALL last div_q+1 clocks, where div_q is the active divider; div_q=0 gives one clock per phase.
REQ-019 After WRITE the phase SHALL return to COUNT with idx+1; after WRITE of idx N-1 the FSM SHALL enter DONE.
REQ-020 DONE SHALL last exactly one cycle with step_done=1, then go to RUN at idx 0 if cont=1 and enable=1, else IDLE.
REQ-021 ph_count, ph_read and ph_write SHALL be high in COUNT, READ and WRITE respectively; all SHALL be low in SETTLE, IDLE and DONE.
REQ-022 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-023 enable=0 in RUN SHALL freeze the divider, phase and idx; phase strobes SHALL be low while frozen; resuming SHALL continue in the same phase with the divider count preserved.
REQ-024 step_req while busy SHALL be ignored and SHALL increment overrun_cnt, saturating at 16'hFFFF.
REQ-025 step_req in DONE SHALL count as an overrun; cont=1 SHALL NOT count as one.
REQ-026 cfg_load in IDLE SHALL update div_q on the next cycle; cfg_load while busy SHALL hold div_in as pending, to be applied at the next entry into RUN from IDLE or DONE; the last load SHALL win.
REQ-027 step_cnt SHALL increment on each DONE and wrap modulo 2**32.
REQ-028 Total RUN duration per step SHALL be 4*N*(div_q+1) clocks when enable stays high.

Reset
REQ-029 reset_n=0 SHALL asynchronously force state IDLE, idx 0, all strobes 0, busy 0, step_done 0, overrun_cnt 0, step_cnt 0, div_q 0, and clear the pending flag.
REQ-030 Reset asserted mid-step SHALL abort the step with no step_done; sequencing SHALL restart only on a new step_req.

Configuration
REQ-031 Macro SCHED_STEP_CNT_EN defined SHALL implement step_cnt per REQ-027; undefined, step_cnt SHALL be tied to 0 and its register omitted.

Structure
REQ-032 Package neuron_sched_pkg SHALL hold the state and phase enumerations, the OVR_W=16 and STEP_W=32 constants, and the phase encoding.
REQ-033 The divider SHALL be a sub-module named phase_tick_div (inputs: clk, reset_n, hold, clear, div_q; output: tick).

Verification
REQ-034 NN=2, div_in=0, a single step_req -> busy high for 16 RUN cycles plus 1 DONE cycle; idx sequence 0,0,0,0,1,…,3; one step_done pulse; step_cnt=1.
REQ-035 div_in=2 loaded in IDLE, then a step -> each strobe 3 clocks wide; RUN lasts 48 clocks for NN=2.
REQ-036 enable low for 5 cycles during READ of idx 1 -> idx and phase frozen, strobes low, READ resumes with remaining tick count; total RUN is 5 cycles longer.
REQ-037 Three step_req pulses mid-step, then cfg_load div_in=1 mid-step -> overrun_cnt=3; the current step keeps the old timing and the next step uses 2-clock phases.
REQ-038 cont=1 for three steps, with reset_n pulsed low during step 3 at idx 2 -> step_done pulses twice; outputs reset immediately; FSM stays IDLE.
